// File: rtl/adder32_arbiter.sv
// adder32_arbiter: round-robin sharing of one registered 32-bit adder
// between NUM_REQ requesters. The result is held in one shared slot,
// tagged with the owning requester index.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is a one-hot grant)
//   req_a, req_b      packed operands, requester i at bits [32*i+31:32*i]
//   resp_valid/ready  result handshake with backpressure
//   resp_id, resp_sum owner index and (a+b) mod 2^32

// Adder with one cycle of registered latency and no reset.
module adder32_sync #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);
    always_ff @(posedge clk) begin
        sum <= a + b;
    end
endmodule

module adder32_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_sum,
    input  logic                  resp_ready
);
    localparam int unsigned DATA_W = 32;

    logic [ID_W-1:0]   rr_ptr;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;

    logic              can_issue;
    logic              hi_hit;
    logic              lo_hit;
    logic [ID_W-1:0]   hi_id;
    logic [ID_W-1:0]   lo_id;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   next_ptr;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;

    // A new grant is allowed only when the result slot is empty or retiring.
    assign can_issue = !resp_valid || resp_ready;

    // Lowest valid index at or above rr_ptr wins; otherwise the lowest valid
    // index below it (wrap-around). Descending scan leaves the lowest hit.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i >= int'(rr_ptr)) begin
                    hi_hit = 1'b1;
                    hi_id  = ID_W'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_id  = ID_W'(i);
                end
            end
        end
    end

    assign grant_valid = !reset && can_issue && (hi_hit || lo_hit);
    assign grant_id    = hi_hit ? hi_id : lo_id;
    assign next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // One-hot grant decode.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_valid && (grant_id == ID_W'(i));
        end
    end

    // Granted operands feed the adder directly; otherwise replay the held
    // operands so the registered sum stays stable under backpressure.
    always_comb begin
        add_a = hold_a;
        add_b = hold_b;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_id == ID_W'(i))) begin
                add_a = req_a[DATA_W*i +: DATA_W];
                add_b = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    adder32_sync #(
        .DATA_W(DATA_W)
    ) u_adder (
        .clk (clk),
        .a   (add_a),
        .b   (add_b),
        .sum (resp_sum)
    );

    // Result slot, owner tag, operand hold and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            rr_ptr     <= '0;
            hold_a     <= '0;
            hold_b     <= '0;
        end else if (grant_valid) begin
            resp_valid <= 1'b1;
            resp_id    <= grant_id;
            rr_ptr     <= next_ptr;
            hold_a     <= add_a;
            hold_b     <= add_b;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: doc/adder32_arbiter.md
Name: adder32_arbiter

Overview:
- Shares one clocked 32-bit adder (adder32_sync, 1-cycle registered latency) between NUM_REQ requesters, e.g. the PC incrementer, branch-target calculation and load/store address generation.
- Arbitration is round-robin. Each requester uses a valid/ready request handshake.
- One result register is shared by all requesters and is tagged with the requester index. The result supports backpressure and is held stable while stalled.

Parameters:
NUM_REQ, 3, number of requesters (legal range 2..4)
ID_W, 2, width of the requester index; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_a  input  32*NUM_REQ  operand A; requester i occupies bits [32*i+31:32*i]
req_b  input  32*NUM_REQ  operand B; same packing as req_a
req_ready  output  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] && req_ready[i]
resp_valid  output  1  result valid
resp_id  output  ID_W  index of the requester that owns resp_sum
resp_sum  output  32  (a+b) mod 2^32
resp_ready  input  1  consumer accepts the result

Behaviour:
- Reset values (synchronous: the cycle after reset is high at posedge):
  - resp_valid=0, resp_id=0, rr_ptr=0, held operands=0.
  - req_ready=0 while reset is high.
  - resp_sum is don't-care while resp_valid=0, because the adder has no reset.
- Issue condition: can_issue = !resp_valid || resp_ready. A grant is never issued while the result slot is stalled.
- Grant selection:
  - req_ready is combinational from req_valid, rr_ptr and can_issue.
  - The first i in the order rr_ptr, rr_ptr+1, ... (mod NUM_REQ) with req_valid[i]=1 is granted. At most one bit is set.
  - req_ready is all-zero when !can_issue, when no request is valid, or when reset is high.
- On grant to requester g at cycle t:
  - req_a[g] and req_b[g] drive the adder directly in cycle t.
  - The operands are also captured into hold registers; resp_id<=g; resp_valid<=1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: the result is visible at cycle t+1, with resp_sum = req_a[g]+req_b[g] as sampled at t. Sustained throughput is 1 result per cycle when resp_ready is high.
- No grant in a cycle:
  - The adder is driven from the hold registers, so resp_sum stays stable.
  - If resp_valid && resp_ready, then resp_valid<=0.
  - If resp_valid && !resp_ready, then resp_valid, resp_id and resp_sum are held unchanged.
  - rr_ptr is unchanged.
- Accept and grant in the same cycle (resp_valid && resp_ready together with a new grant): the old result retires and the new result is presented at t+1 with no bubble.
- Width rules: no carry-out; overflow wraps modulo 2^32.
- Requester contract: req_a and req_b must be stable while req_valid is high and not yet granted. The arbiter does not buffer requests that are not granted.
- Reset mid-operation: an in-flight or stalled result is dropped (resp_valid=0 the next cycle), rr_ptr returns to 0, and no grant is issued during reset.
- Indices NUM_REQ..2**ID_W-1 never appear on resp_id.
- Formal properties:
  - req_ready is one-hot or zero.
  - resp_valid && !resp_ready implies resp_id and resp_sum are $stable next cycle.
  - resp_sum == $past(granted a) + $past(granted b).

Test Plan:
- Single requester: reset, then req_valid=3'b001, a0=0x00001000, b0=0x4 -> req_ready=001 at t; at t+1 resp_valid=1, resp_id=0, resp_sum=0x00001004.
- Wrap-around: a1=0xFFFFFFFF, b1=0x2 -> resp_sum=0x00000001, resp_id=1, no carry flagged.
- Round-robin fairness: all three requesters valid continuously with resp_ready=1 -> grants 0,1,2,0,1,2 on consecutive cycles; resp_id follows one cycle later with no bubbles.
- Backpressure: grant requester 2 (a=7, b=8); hold resp_ready=0 for 3 cycles with all requesters valid -> resp_sum=15 and resp_id=2 held stable, req_ready=000 throughout. On the resp_ready=1 cycle, requester 0 is granted in the same cycle and its result appears next cycle.
- Sparse requests: req_valid=3'b100 with rr_ptr=0 -> requester 2 is granted and rr_ptr becomes 0. Then 3'b011 -> requester 0 is granted, then requester 1.
- Reset mid-stall: stalled result with resp_valid=1, assert reset for 1 cycle -> resp_valid=0 and req_ready=000 during reset. After reset, a request from requester 1 alone is granted first, since only 1 is valid and rr_ptr=0.
